// File: rtl/apb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// apb_regfile_pkg
// Shared types and helpers for the apb_regfile_slave block.
//   state_t    : APB slave FSM state (IDLE, ACCESS)
//   calc_lsb   : number of byte-address bits below the word index
//   status_idx : word index of the read-only STATUS register
// ---------------------------------------------------------------------------
package apb_regfile_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Byte-offset bits inside one data word (log2 of bytes per word).
    function automatic int calc_lsb(input int data_w);
        case (data_w)
            8:       return 0;
            16:      return 1;
            32:      return 2;
            64:      return 3;
            default: return 2;
        endcase
    endfunction

    // STATUS always occupies the highest register slot.
    function automatic int status_idx(input int num_regs);
        return num_regs - 1;
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// ---------------------------------------------------------------------------
// apb_wait_ctr
// Wait-state counter for the APB access phase.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear (priority over en)
//   en    : count one cycle while not yet done
//   done  : counter has reached WAIT_STATES
// ---------------------------------------------------------------------------
module apb_wait_ctr #(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    assign done = (cnt_reg == 4'(WAIT_STATES));

    // Counter saturates at WAIT_STATES so done stays high until cleared.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (en && !done) begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave
// Parametrised APB register file: NUM_REGS-1 read/write word registers plus
// one read-only STATUS word (highest index) that returns hw_status.
// Optional macro APB_PSTRB_EN adds the PSTRB port and byte-lane writes.
// Ports:
//   clk, PRESETn          : APB clock / asynchronous active-low reset
//   PSEL, PENABLE, PWRITE : APB control
//   PADDR, PWDATA, PSTRB  : byte address, write data, byte strobes (optional)
//   PRDATA, PREADY        : read data (zero unless a good read completes), ready
//   PSLVERR               : error (out-of-range index or write to STATUS)
//   hw_status             : value returned on STATUS reads
//   reg_q                 : flattened register contents, STATUS slot is zero
// ---------------------------------------------------------------------------
module apb_regfile_slave
    import apb_regfile_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 8,
    parameter int                WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                       clk,
    input  logic                       PRESETn,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [ADDR_W-1:0]          PADDR,
    input  logic [DATA_W-1:0]          PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0]        PSTRB,
`endif
    output logic [DATA_W-1:0]          PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    input  logic [DATA_W-1:0]          hw_status,
    output logic [NUM_REGS*DATA_W-1:0] reg_q
);

    localparam int LSB    = calc_lsb(DATA_W);
    localparam int IDX_W  = ADDR_W - LSB;
    localparam int STATUS = status_idx(NUM_REGS);
    localparam int NB     = DATA_W / 8;

    genvar gi;

    state_t state_reg;
    state_t state_next;

    logic [IDX_W-1:0]               idx;
    logic                           idx_oob;
    logic                           is_status;
    logic                           acc_err;
    logic                           ctr_done;
    logic                           wr_en;
    logic [DATA_W-1:0]              wr_mask;
    logic [DATA_W-1:0]              rd_val;
    logic [(NUM_REGS-1)*DATA_W-1:0] rw_flat;

    assign idx       = PADDR[ADDR_W-1:LSB];
    assign idx_oob   = (32'(idx) >= 32'(NUM_REGS));
    assign is_status = (32'(idx) == 32'(STATUS));
    assign acc_err   = idx_oob || (PWRITE && is_status);

    apb_wait_ctr #(
        .WAIT_STATES(WAIT_STATES)
    ) u_wait_ctr (
        .clk  (clk),
        .rst_n(PRESETn),
        .clr  (state_reg == IDLE),
        .en   (state_reg == ACCESS),
        .done (ctr_done)
    );

    // State register
    always_ff @(posedge clk or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: only a proper setup phase (PENABLE low) opens an access.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_next = IDLE;
                end else if (PENABLE && ctr_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: everything is qualified by the completion cycle.
    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = '0;
        wr_en   = 1'b0;
        if (state_reg == ACCESS && ctr_done) begin
            PREADY  = 1'b1;
            PSLVERR = acc_err;
            if (!PWRITE && !acc_err) begin
                PRDATA = rd_val;
            end
            wr_en = PSEL && PENABLE && PWRITE && !acc_err;
        end
    end

    // Byte-lane write mask
    generate
        for (gi = 0; gi < NB; gi++) begin : g_mask
`ifdef APB_PSTRB_EN
            assign wr_mask[gi*8 +: 8] = {8{PSTRB[gi]}};
`else
            assign wr_mask[gi*8 +: 8] = 8'hFF;
`endif
        end
    endgenerate

    // Read/write registers, one flop bank per slot
    generate
        for (gi = 0; gi < NUM_REGS - 1; gi++) begin : g_reg
            logic [DATA_W-1:0] q_reg;
            always_ff @(posedge clk or negedge PRESETn) begin
                if (!PRESETn) begin
                    q_reg <= RESET_VAL;
                end else if (wr_en && (32'(idx) == 32'(gi))) begin
                    q_reg <= (q_reg & ~wr_mask) | (PWDATA & wr_mask);
                end
            end
            assign rw_flat[gi*DATA_W +: DATA_W] = q_reg;
        end
    endgenerate

    // Read mux; out-of-range indices fall through to zero.
    always_comb begin
        rd_val = '0;
        if (is_status) begin
            rd_val = hw_status;
        end else begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (32'(idx) == 32'(i)) begin
                    rd_val = rw_flat[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign reg_q = {{DATA_W{1'b0}}, rw_flat};

endmodule

// File: tb/tb_apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_regfile_slave
// Two instances (0 and 3 wait states) on a shared bus with separate PSEL,
// compared against an array-based register model.
// ---------------------------------------------------------------------------
module tb_apb_regfile_slave;

    localparam int WS0 = 0;
    localparam int WS1 = 3;

    logic        clk = 1'b0;
    logic        presetn;
    logic [1:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] hw_status;

    logic [31:0]  prdata0, prdata1;
    logic         pready0, pready1;
    logic         pslverr0, pslverr1;
    logic [255:0] regq0, regq1;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [2][8];

    always #5 clk = ~clk;

    apb_regfile_slave #(
        .ADDR_W(8), .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(WS0), .RESET_VAL(32'h0)
    ) dut0 (
        .clk(clk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0),
        .hw_status(hw_status), .reg_q(regq0)
    );

    apb_regfile_slave #(
        .ADDR_W(8), .DATA_W(32), .NUM_REGS(8), .WAIT_STATES(WS1), .RESET_VAL(32'h0)
    ) dut1 (
        .clk(clk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1),
        .hw_status(hw_status), .reg_q(regq1)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? pready0 : pready1;
    endfunction

    function automatic logic [255:0] rq(input int d);
        return (d == 0) ? regq0 : regq1;
    endfunction

    function automatic int ws(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    function automatic logic [255:0] model_flat(input int d);
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < 7; i++) f[i*32 +: 32] = mdl[d][i];
        return f;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) mdl[d][i] = 32'h0;
    endtask

    // One complete APB transfer on instance d; checks latency, response and
    // register image, then updates the model after the completion edge.
    task automatic xfer(input int d, input bit wr, input logic [7:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        output logic [31:0] rdata);
        int          idx;
        int          waits;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [31:0] mask;
        logic [5:0]  a_hi;
        a_hi    = addr[7:2];
        idx     = int'(a_hi);
        exp_err = (idx >= 8) || (wr && idx == 7);
        exp_rd  = 32'h0;
        if (!wr && !exp_err) exp_rd = (idx == 7) ? hw_status : mdl[d][idx];
        rdata = 32'h0;

        @(negedge clk);
        psel    = 2'b00;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        pstrb   = strb;
        @(negedge clk);
        penable = 1'b1;
        waits   = 0;
        while (!rdy(d) && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        check("wait_cycles", 256'(waits), 256'(ws(d)));
        if (rdy(d)) begin
            check("pslverr", (d == 0) ? pslverr0 : pslverr1, exp_err);
            rdata = (d == 0) ? prdata0 : prdata1;
            check("prdata", rdata, exp_rd);
            check("regq_before_edge", rq(d), model_flat(d));
        end
        @(posedge clk);
        #1;
        if (wr && !exp_err) begin
`ifdef APB_PSTRB_EN
            for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{strb[b]}};
`else
            mask = 32'hFFFF_FFFF;
`endif
            mdl[d][idx] = (mdl[d][idx] & ~mask) | (wd & mask);
        end
        check("regq_after_edge", rq(d), model_flat(d));
        check("ready_after_done", rdy(d), 1'b0);
        $display("xfer dut%0d %s addr=%h wdata=%h strb=%h rdata=%h err=%0d waits=%0d",
                 d, wr ? "WR" : "RD", addr, wd, strb, rdata, exp_err, waits);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        psel    = 2'b00;
        penable = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        presetn   = 1'b0;
        psel      = 2'b00;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = 8'h0;
        pwdata    = 32'h0;
        pstrb     = 4'hF;
        hw_status = 32'hA5A5_0001;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pready0", pready0, 1'b0);
        check("rst_pready1", pready1, 1'b0);
        check("rst_pslverr0", pslverr0, 1'b0);
        check("rst_prdata0", prdata0, 32'h0);
        check("rst_regq0", regq0, 256'h0);
        check("rst_regq1", regq1, 256'h0);
        presetn = 1'b1;

        // Read every index on both instances
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) xfer(d, 1'b0, 8'(i * 4), 32'h0, 4'hF, rd);
        xfer(0, 1'b0, 8'h1C, 32'h0, 4'hF, rd);
        check("status_read", rd, 32'hA5A5_0001);

        // Write then back-to-back read, zero wait states
        xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, rd);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, rd);
        check("readback_const", rd, 32'hDEAD_BEEF);

        // Three wait states
        xfer(1, 1'b1, 8'h08, 32'h0000_1234, 4'hF, rd);
        check("slot2_const", regq1[64 +: 32], 32'h0000_1234);

        // Error responses
        xfer(0, 1'b0, 8'h20, 32'h0, 4'hF, rd);
        xfer(0, 1'b1, 8'h20, 32'h1111_2222, 4'hF, rd);
        xfer(0, 1'b1, 8'h1C, 32'hFFFF_FFFF, 4'hF, rd);
        xfer(1, 1'b1, 8'h1C, 32'hFFFF_FFFF, 4'hF, rd);

        // PENABLE without a setup phase is ignored
        bus_idle();
        @(negedge clk);
        psel    = 2'b11;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 8'h10;
        pwdata  = 32'hBAD0_BAD0;
        repeat (3) begin
            @(negedge clk);
            check("noset_pready0", pready0, 1'b0);
            check("noset_pready1", pready1, 1'b0);
        end
        check("noset_regq0", regq0, model_flat(0));
        bus_idle();

        // Reset during an access aborts the write
        @(negedge clk);
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h55;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        presetn = 1'b0;
        model_reset();
        #1;
        check("midrst_pready", pready1, 1'b0);
        check("midrst_regq1", regq1, 256'h0);
        check("midrst_regq0", regq0, 256'h0);
        @(negedge clk);
        presetn = 1'b1;
        psel    = 2'b00;
        penable = 1'b0;
        @(negedge clk);
        check("postrst_pready", pready1, 1'b0);
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'hF, rd);

        // PSEL dropped during an access
        @(negedge clk);
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h77;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel    = 2'b00;
        penable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_pready", pready1, 1'b0);
            check("abort_regq1", regq1, model_flat(1));
        end
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'hF, rd);

`ifdef APB_PSTRB_EN
        xfer(0, 1'b1, 8'h00, 32'h1122_3344, 4'hF, rd);
        xfer(0, 1'b1, 8'h00, 32'hAABB_CCDD, 4'b0101, rd);
        xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, rd);
        check("pstrb_merge", rd, 32'h11BB_33DD);
        xfer(0, 1'b1, 8'h00, 32'h0, 4'b0000, rd);
        xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, rd);
        check("pstrb_zero", rd, 32'h11BB_33DD);
`endif

        // Randomised traffic
        for (int n = 0; n < 160; n++) begin
            int          d;
            bit          w;
            logic [7:0]  a;
            logic [31:0] wd;
            logic [3:0]  s;
            d  = int'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 63));
            wd = $urandom;
            s  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) hw_status = $urandom;
            if ($urandom_range(0, 3) == 0) bus_idle();
            xfer(d, w, a, wd, s, rd);
        end
        bus_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
